// File: rtl/fifo_ram.sv
// Sample storage for the input-port buffer.
// Synchronous write, asynchronous read.
module fifo_ram #(
  parameter int W     = 16,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/proc_in_fifo.sv
// Input-port FIFO feeding the core's io_in with show-ahead reads
// and a threshold interrupt for ISR-driven draining.
module proc_in_fifo #(
  parameter int NUBITS = 16,
  parameter int NBIOIN = 2,
  parameter int PORT   = 0,
  parameter int DEPTH  = 8,
  parameter int ITRTHR = 1,
  parameter int ITREN  = 1,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic [NUBITS-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              req_in,
  input  logic [NBIOIN-1:0] addr_in,
  output logic [NUBITS-1:0] io_in,
  output logic              itr,
  output logic [LW-1:0]     level,
  output logic              udf
);

  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [LW-1:0]     level_nx;
  logic [NUBITS-1:0] rdata;
  logic              empty;
  logic              hit;
  logic              push;
  logic              pop;
  logic              fire;

  assign empty   = (level == '0);
  assign s_ready = (level != LW'(DEPTH));
  assign hit     = req_in & (addr_in == NBIOIN'(PORT));
  assign push    = s_valid & s_ready;
  assign pop     = hit & ~empty;

  always_comb begin
    level_nx = level;
    unique case ({push, pop})
      2'b10:   level_nx = level + 1'b1;
      2'b01:   level_nx = level - 1'b1;
      default: level_nx = level;
    endcase
  end

  // Fire only on the upward crossing so a sustained fill level stays quiet
  assign fire = (ITREN != 0)
              && (level_nx >= LW'(ITRTHR))
              && (level < LW'(ITRTHR));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      udf    <= 1'b0;
      itr    <= 1'b0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      udf    <= 1'b0;
      itr    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level_nx;
      udf   <= udf | (hit & empty);
      itr   <= fire;
    end
  end

  fifo_ram #(
    .W     (NUBITS),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (push & ~clr),
    .waddr (wr_ptr),
    .wdata (s_data),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  // RAM content is undefined when empty, so gate it off
  assign io_in = empty ? '0 : rdata;

endmodule

// File: tb/tb_proc_in_fifo.sv
// Directed bench for proc_in_fifo.
// Built with ITRTHR=2 so the interrupt crossing is exercised.
module tb_proc_in_fifo;

  logic        clk;
  logic        rst;
  logic        clr;
  logic [15:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic        req_in;
  logic [1:0]  addr_in;
  logic [15:0] io_in;
  logic        itr;
  logic [3:0]  level;
  logic        udf;

  int n_chk;
  int n_pass;

  proc_in_fifo #(
    .NUBITS (16),
    .NBIOIN (2),
    .PORT   (0),
    .DEPTH  (8),
    .ITRTHR (2),
    .ITREN  (1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .req_in  (req_in),
    .addr_in (addr_in),
    .io_in   (io_in),
    .itr     (itr),
    .level   (level),
    .udf     (udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input logic [15:0] d);
    s_data  = d;
    s_valid = 1'b1;
    step();
    s_valid = 1'b0;
  endtask

  task automatic pop1(input logic [15:0] exp, input string tag);
    req_in  = 1'b1;
    addr_in = 2'd0;
    chk(tag, 32'(io_in), 32'(exp));
    step();
    req_in  = 1'b0;
  endtask

  initial begin
    n_chk   = 0;
    n_pass  = 0;
    rst     = 1'b0;
    clr     = 1'b0;
    s_data  = '0;
    s_valid = 1'b0;
    req_in  = 1'b0;
    addr_in = 2'd0;
    #23;
    chk("rst_level", 32'(level), 0);
    chk("rst_ready", 32'(s_ready), 1);
    chk("rst_itr", 32'(itr), 0);
    chk("rst_udf", 32'(udf), 0);
    chk("rst_io", 32'(io_in), 0);
    step();
    rst = 1'b1;
    step();

    // in-order push/pop
    push1(16'h0011);
    push1(16'h0022);
    push1(16'h0033);
    chk("t1_level3", 32'(level), 3);
    pop1(16'h0011, "t1_pop0");
    pop1(16'h0022, "t1_pop1");
    pop1(16'h0033, "t1_pop2");
    chk("t1_level0", 32'(level), 0);
    chk("t1_udf", 32'(udf), 0);

    // fill to full with s_valid held, wrap pointers
    s_valid = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      s_data = 16'(16'h0100 + i);
      step();
    end
    chk("t2_full_lvl", 32'(level), 8);
    chk("t2_full_rdy", 32'(s_ready), 0);
    s_data = 16'h0109;
    step();
    chk("t2_held_lvl", 32'(level), 8);
    req_in = 1'b1;
    chk("t2_pop_io", 32'(io_in), 32'h0101);
    step();
    req_in = 1'b0;
    chk("t2_after_pop", 32'(level), 7);
    step();
    s_valid = 1'b0;
    chk("t2_ninth_lvl", 32'(level), 8);
    for (int i = 2; i <= 9; i++) begin
      pop1(16'(16'h0100 + i), "t2_drain");
    end
    chk("t2_empty", 32'(level), 0);

    // simultaneous push and pop at level 4
    for (int i = 1; i <= 4; i++) push1(16'(16'h0030 + i));
    chk("t3_lvl4", 32'(level), 4);
    s_data  = 16'h0035;
    s_valid = 1'b1;
    req_in  = 1'b1;
    chk("t3_io_pre", 32'(io_in), 32'h0031);
    step();
    s_valid = 1'b0;
    req_in  = 1'b0;
    chk("t3_lvl_same", 32'(level), 4);
    chk("t3_io_adv", 32'(io_in), 32'h0032);
    for (int i = 2; i <= 5; i++) pop1(16'(16'h0030 + i), "t3_drain");
    chk("t3_empty", 32'(level), 0);

    // underflow, sticky udf, clr, foreign port
    req_in = 1'b1;
    chk("t4_io_zero", 32'(io_in), 0);
    step();
    req_in = 1'b0;
    chk("t4_udf_set", 32'(udf), 1);
    chk("t4_lvl0", 32'(level), 0);
    step();
    chk("t4_udf_stk", 32'(udf), 1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("t4_clr_udf", 32'(udf), 0);
    chk("t4_clr_lvl", 32'(level), 0);
    req_in  = 1'b1;
    addr_in = 2'd1;
    step();
    req_in  = 1'b0;
    addr_in = 2'd0;
    chk("t4_other_port", 32'(udf), 0);

    // interrupt at threshold 2
    push1(16'h0051);
    chk("t5_itr_l1", 32'(itr), 0);
    push1(16'h0052);
    chk("t5_itr_l2", 32'(itr), 1);
    push1(16'h0053);
    chk("t5_itr_l3", 32'(itr), 0);
    pop1(16'h0051, "t5_pop_a");
    chk("t5_itr_d2", 32'(itr), 0);
    pop1(16'h0052, "t5_pop_b");
    chk("t5_lvl1", 32'(level), 1);
    push1(16'h0054);
    chk("t5_itr_rearm", 32'(itr), 1);
    step();
    chk("t5_itr_once", 32'(itr), 0);

    // async reset mid-stream at level 5
    push1(16'h0055);
    push1(16'h0056);
    push1(16'h0057);
    chk("t6_lvl5", 32'(level), 5);
    s_data  = 16'h0058;
    s_valid = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    chk("t6_rst_lvl", 32'(level), 0);
    chk("t6_rst_rdy", 32'(s_ready), 1);
    chk("t6_rst_itr", 32'(itr), 0);
    chk("t6_rst_io", 32'(io_in), 0);
    s_valid = 1'b0;
    #1;
    rst = 1'b1;
    step();
    push1(16'h00ab);
    chk("t6_post_lvl", 32'(level), 1);
    chk("t6_post_io", 32'(io_in), 32'h00ab);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
